// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, funct3
// access codes, access-size decode and the default bus timeout.
package lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2,
        S_DONE = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int unsigned LSU_TIMEOUT_DEFAULT = 255;

    // Unlisted funct3 codes fall through to a full-word access.
    function automatic lsu_size_e size_of(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: size_of = SZ_B;
            F3_H, F3_HU: size_of = SZ_H;
            default:     size_of = SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: store byte enables, store data replication and
// misalignment detection; load lane selection with sign/zero extension.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata_rep,
    output logic        st_misaligned,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    lsu_size_e   st_size;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign st_size = size_of(st_funct3);

    always_comb begin
        st_be         = 4'b1111;
        st_wdata_rep  = st_wdata;
        st_misaligned = 1'b0;
        case (st_size)
            SZ_B: begin
                st_be        = 4'b0001 << st_addr_lo;
                st_wdata_rep = {4{st_wdata[7:0]}};
            end
            SZ_H: begin
                st_be         = st_addr_lo[1] ? 4'b1100 : 4'b0011;
                st_wdata_rep  = {2{st_wdata[15:0]}};
                st_misaligned = st_addr_lo[0];
            end
            default: begin
                st_misaligned = (st_addr_lo != 2'b00);
            end
        endcase
    end

    assign ld_byte = ld_word[{ld_addr_lo, 3'b000} +: 8];
    assign ld_half = ld_addr_lo[1] ? ld_word[31:16] : ld_word[15:0];

    always_comb begin
        ld_data = ld_word;
        case (ld_funct3)
            F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_data = {24'd0, ld_byte};
            F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_data = {16'd0, ld_half};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: request/grant/response bus handshake with timeout, stalling
// the single-cycle core while an access is outstanding.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_rd,
    input  logic        mem_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misalign,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    lsu_state_e  state_q, state_d;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [29:0] waddr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [15:0] cnt_q;

    logic [3:0]  st_be;
    logic [31:0] st_wdata_rep;
    logic        st_mis;
    logic [31:0] ld_data;

    logic access, start, busy, timeout, capture;
    logic stall_c, misalign_c, req_c;

    lsu_lane_align u_align (
        .st_funct3     (funct3),
        .st_addr_lo    (addr[1:0]),
        .st_wdata      (wdata),
        .st_be         (st_be),
        .st_wdata_rep  (st_wdata_rep),
        .st_misaligned (st_mis),
        .ld_funct3     (f3_q),
        .ld_addr_lo    (off_q),
        .ld_word       (bus_rdata),
        .ld_data       (ld_data)
    );

    assign access  = mem_rd | mem_we;
    assign busy    = (state_q == S_REQ) || (state_q == S_RSP);
    assign timeout = busy && (cnt_q == TO_LAST);
    assign start   = (state_q == S_IDLE) && access && !st_mis;
    assign capture = (state_q == S_RSP) && bus_rvalid && !timeout;

    always_comb begin
        state_d    = state_q;
        stall_c    = 1'b0;
        misalign_c = 1'b0;
        req_c      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (access) begin
                    if (st_mis) begin
                        misalign_c = 1'b1;
                    end else begin
                        stall_c = 1'b1;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                stall_c = 1'b1;
                if (timeout) begin
                    state_d = S_DONE;
                end else begin
                    req_c = 1'b1;
                    if (bus_gnt) begin
                        state_d = we_q ? S_DONE : S_RSP;
                    end
                end
            end
            S_RSP: begin
                stall_c = 1'b1;
                if (timeout || bus_rvalid) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            off_q   <= 2'd0;
            waddr_q <= 30'd0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            if (start) begin
                we_q    <= mem_we;
                f3_q    <= funct3;
                off_q   <= addr[1:0];
                waddr_q <= addr[31:2];
                be_q    <= st_be;
                wdata_q <= mem_we ? st_wdata_rep : 32'd0;
                cnt_q   <= 16'd0;
            end else if (busy) begin
                cnt_q <= cnt_q + 16'd1;
            end
            // Load data is only ever overwritten by a capture or an error clear.
            if (capture) begin
                rdata_q <= ld_data;
            end else if (misalign_c || timeout) begin
                rdata_q <= 32'd0;
            end
        end
    end

    // IDLE-side outputs depend on live core inputs, so hold them low in reset.
    assign stall     = stall_c & reset;
    assign misalign  = misalign_c & reset;
    assign bus_err   = timeout;
    assign bus_req   = req_c;
    assign bus_we    = req_c & we_q;
    assign bus_addr  = {waddr_q, 2'b00};
    assign bus_be    = be_q;
    assign bus_wdata = wdata_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// accesses with random bus latencies, checked against a byte-arithmetic model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_rd, mem_we;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        stall, misalign, bus_err, bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt, bus_rvalid;
    logic [31:0] bus_rdata;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    logic [31:0] model_rdata = 32'd0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_rd     (mem_rd),
        .mem_we     (mem_we),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .stall      (stall),
        .misalign   (misalign),
        .bus_err    (bus_err),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_gnt    (bus_gnt),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    // ---------------- reference model ----------------
    function automatic int size_bytes(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        int sz  = size_bytes(f3);
        int off = int'(a % 4);
        return 4'(((1 << sz) - 1) << off);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        int sz = size_bytes(f3);
        if (sz == 1) return (wd & 32'h0000_00FF) * 32'h0101_0101;
        if (sz == 2) return (wd & 32'h0000_FFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
        int sz = size_bytes(f3);
        logic [31:0] v = w >> (8 * int'(a % 4));
        if (sz == 1) begin
            v = v & 32'hFF;
            if (!f3[2] && v >= 32'd128) v = v | 32'hFFFF_FF00;
        end else if (sz == 2) begin
            v = v & 32'hFFFF;
            if (!f3[2] && v >= 32'd32768) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    // One complete access, entered and left just after a rising edge.
    task automatic do_access(input string nm, input logic we, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd,
                             input int gl, input int rl, input logic [31:0] rw,
                             output int n_stall);
        int sz = size_bytes(f3);
        logic mis = (int'(a % 4) % sz) != 0;
        logic [3:0]  eb = model_be(f3, a);
        logic [31:0] ew = model_wdata(f3, wd);
        int exp_stall = mis ? 0 : (2 + gl + (we ? 0 : rl + 1));
        n_stall = 0;
        mem_we = we;
        mem_rd = we ? 1'($urandom_range(0, 1)) : 1'b1;
        funct3 = f3; addr = a; wdata = wd;
        @(negedge clk);
        chk_cnt++; if (misalign !== mis) $display("FAIL %s misalign: got %b expected %b", nm, misalign, mis); else pass_cnt++;
        chk_cnt++; if (bus_req !== 1'b0) $display("FAIL %s idle_req: got %b expected 0", nm, bus_req); else pass_cnt++;
        n_stall += int'(stall);
        if (mis) begin
            chk_cnt++; if (stall !== 1'b0) $display("FAIL %s mis_stall: got %b expected 0", nm, stall); else pass_cnt++;
            @(posedge clk); #1;
            mem_rd = 1'b0; mem_we = 1'b0;
            model_rdata = 32'd0;
            chk_cnt++; if (rdata !== model_rdata) $display("FAIL %s mis_rdata: got %h expected %h", nm, rdata, model_rdata); else pass_cnt++;
            $display("txn %s we=%b f3=%0d addr=%h misaligned rdata=%h", nm, we, f3, a, rdata);
            return;
        end
        @(posedge clk); #1;
        for (int i = 0; i <= gl; i++) begin
            bus_gnt    = (i == gl);
            bus_rvalid = 1'($urandom_range(0, 1));
            bus_rdata  = $urandom;
            @(negedge clk);
            chk_cnt++; if (bus_req !== 1'b1) $display("FAIL %s req: got %b expected 1", nm, bus_req); else pass_cnt++;
            chk_cnt++; if (bus_we !== we) $display("FAIL %s bus_we: got %b expected %b", nm, bus_we, we); else pass_cnt++;
            chk_cnt++; if (bus_addr !== (a & 32'hFFFF_FFFC)) $display("FAIL %s bus_addr: got %h expected %h", nm, bus_addr, a & 32'hFFFF_FFFC); else pass_cnt++;
            chk_cnt++; if (bus_be !== eb) $display("FAIL %s bus_be: got %b expected %b", nm, bus_be, eb); else pass_cnt++;
            if (we) begin
                chk_cnt++; if (bus_wdata !== ew) $display("FAIL %s bus_wdata: got %h expected %h", nm, bus_wdata, ew); else pass_cnt++;
            end
            n_stall += int'(stall);
            @(posedge clk); #1;
        end
        bus_gnt = 1'b0;
        bus_rvalid = 1'b0;
        if (!we) begin
            for (int j = 0; j <= rl; j++) begin
                bus_rvalid = (j == rl);
                bus_rdata  = (j == rl) ? rw : $urandom;
                @(negedge clk);
                chk_cnt++; if (bus_req !== 1'b0) $display("FAIL %s rsp_req: got %b expected 0", nm, bus_req); else pass_cnt++;
                n_stall += int'(stall);
                @(posedge clk); #1;
            end
            bus_rvalid = 1'b0;
            model_rdata = model_load(f3, a, rw);
        end
        @(negedge clk);
        n_stall += int'(stall);
        chk_cnt++; if (stall !== 1'b0) $display("FAIL %s done_stall: got %b expected 0", nm, stall); else pass_cnt++;
        chk_cnt++; if (rdata !== model_rdata) $display("FAIL %s rdata: got %h expected %h", nm, rdata, model_rdata); else pass_cnt++;
        chk_cnt++; if (n_stall !== exp_stall) $display("FAIL %s stall_cycles: got %0d expected %0d", nm, n_stall, exp_stall); else pass_cnt++;
        @(posedge clk); #1;
        mem_rd = 1'b0; mem_we = 1'b0;
        $display("txn %s we=%b f3=%0d addr=%h gnt_lat=%0d rv_lat=%0d be=%b rdata=%h stalls=%0d",
                 nm, we, f3, a, gl, rl, bus_be, rdata, n_stall);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        mem_rd = 0; mem_we = 0; funct3 = 0; addr = 0; wdata = 0;
        bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0;
        @(negedge clk);
        chk_cnt++; if ({stall, misalign, bus_err, bus_req, bus_we} !== 5'b0) $display("FAIL reset_ctrl: got %b expected 00000", {stall, misalign, bus_err, bus_req, bus_we}); else pass_cnt++;
        chk_cnt++; if ({rdata, bus_addr, bus_wdata, bus_be} !== 100'd0) $display("FAIL reset_data: got %h expected 0", {rdata, bus_addr, bus_wdata, bus_be}); else pass_cnt++;
        reset = 1'b1;
        @(posedge clk); #1;
        $display("txn reset released");
    endtask

    task automatic test_store_word();
        int ns;
        do_access("sw", 1'b1, 3'b010, 32'h0000_1000, 32'hDEAD_BEEF, 0, 0, 32'd0, ns);
        chk_cnt++; if (ns !== 2) $display("FAIL sw_stall2: got %0d expected 2", ns); else pass_cnt++;
        chk_cnt++; if (bus_be !== 4'b1111 || bus_addr !== 32'h1000) $display("FAIL sw_fields: got be=%b addr=%h expected be=1111 addr=00001000", bus_be, bus_addr); else pass_cnt++;
    endtask

    task automatic test_store_byte();
        int ns;
        do_access("sb", 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 1, 0, 32'd0, ns);
        chk_cnt++; if (bus_be !== 4'b1000) $display("FAIL sb_be: got %b expected 1000", bus_be); else pass_cnt++;
        chk_cnt++; if (bus_wdata !== 32'hA5A5_A5A5) $display("FAIL sb_wdata: got %h expected a5a5a5a5", bus_wdata); else pass_cnt++;
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3s  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] exps [4] = '{32'hFFFF_FFF1, 32'h0000_00F1, 32'hFFFF_80F1, 32'h0000_80F1};
        int ns;
        for (int k = 0; k < 4; k++) begin
            do_access("ld_ext", 1'b0, f3s[k], 32'h0000_2002, 32'd0, 0, 0, 32'h80F1_7F00, ns);
            chk_cnt++; if (rdata !== exps[k]) $display("FAIL ld_ext_const f3=%0d: got %h expected %h", f3s[k], rdata, exps[k]); else pass_cnt++;
            chk_cnt++; if (ns !== 3) $display("FAIL ld_ext_stall3: got %0d expected 3", ns); else pass_cnt++;
        end
    endtask

    task automatic test_misalign();
        int ns;
        do_access("lw_mis", 1'b0, 3'b010, 32'h0000_3001, 32'd0, 0, 0, 32'd0, ns);
        @(negedge clk);
        chk_cnt++; if (misalign !== 1'b0) $display("FAIL mis_pulse_len: got %b expected 0", misalign); else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        int ns;
        do_access("lw_pre", 1'b0, 3'b010, 32'h0000_4000, 32'd0, 0, 0, 32'h1234_5678, ns);
        mem_rd = 1'b1; funct3 = 3'b010; addr = 32'h0000_4000;
        @(posedge clk); #1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i < 8) begin
                chk_cnt++; if (bus_req !== 1'b1 || bus_err !== 1'b0) $display("FAIL to_wait cyc%0d: got req=%b err=%b expected req=1 err=0", i, bus_req, bus_err); else pass_cnt++;
            end else begin
                chk_cnt++; if (bus_req !== 1'b0 || bus_err !== 1'b1) $display("FAIL to_abort: got req=%b err=%b expected req=0 err=1", bus_req, bus_err); else pass_cnt++;
            end
            @(posedge clk); #1;
        end
        model_rdata = 32'd0;
        @(negedge clk);
        chk_cnt++; if (stall !== 1'b0 || bus_err !== 1'b0) $display("FAIL to_done: got stall=%b err=%b expected 0 0", stall, bus_err); else pass_cnt++;
        chk_cnt++; if (rdata !== model_rdata) $display("FAIL to_rdata: got %h expected %h", rdata, model_rdata); else pass_cnt++;
        @(posedge clk); #1;
        mem_rd = 1'b0;
        bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        bus_rvalid = 1'b0;
        chk_cnt++; if (rdata !== model_rdata) $display("FAIL to_late_rvalid: got %h expected %h", rdata, model_rdata); else pass_cnt++;
        $display("txn timeout abort addr=00004000 rdata=%h", rdata);
    endtask

    task automatic test_reset_mid_rsp();
        int ns;
        do_access("lw_pre2", 1'b0, 3'b010, 32'h0000_5000, 32'd0, 0, 0, 32'hA5A5_0001, ns);
        mem_rd = 1'b1; funct3 = 3'b010; addr = 32'h0000_5004;
        @(posedge clk); #1;
        bus_gnt = 1'b1;
        @(posedge clk); #1;
        bus_gnt = 1'b0;
        #2 reset = 1'b0;
        #1;
        model_rdata = 32'd0;
        chk_cnt++; if ({stall, misalign, bus_err, bus_req, bus_we} !== 5'b0) $display("FAIL rst_mid_ctrl: got %b expected 00000", {stall, misalign, bus_err, bus_req, bus_we}); else pass_cnt++;
        chk_cnt++; if ({rdata, bus_addr, bus_wdata, bus_be} !== 100'd0) $display("FAIL rst_mid_data: got %h expected 0", {rdata, bus_addr, bus_wdata, bus_be}); else pass_cnt++;
        mem_rd = 1'b0;
        bus_rvalid = 1'b1; bus_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        bus_rvalid = 1'b0;
        chk_cnt++; if (rdata !== model_rdata) $display("FAIL rst_late_rvalid: got %h expected %h", rdata, model_rdata); else pass_cnt++;
        $display("txn reset during RSP rdata=%h", rdata);
    endtask

    task automatic test_random();
        int ns;
        for (int n = 0; n < 40; n++) begin
            logic we = 1'($urandom_range(0, 1));
            logic [2:0] f3 = 3'($urandom_range(0, 7));
            logic [31:0] a = $urandom;
            do_access("rand", we, f3, a, $urandom, int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 2)), $urandom, ns);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_store_word();
        test_store_byte();
        test_load_ext();
        test_misalign();
        test_timeout();
        test_reset_mid_rsp();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
